sram_emulator: RTL and testbench
================================

# sram_emulator

Synthesizable single-clock model of the external 16-bit asynchronous SRAM, connected to the pin side of the SRAM controller in place of the physical chip. It lets us run the full image-decompressor datapath on boards or benches without the external part. It answers the controller's pin protocol with the same 2-cycle read latency the controller expects. It also provides a backdoor preload port and activity/error counters for verification.

## Interface
- ADDR_BITS, default 12: implemented address bits; memory depth is 2^ADDR_BITS words.
- Clock_50  input  1  system clock; the controller's pin-side registers use the same clock.
- Resetn  input  1  asynchronous, active-low reset.
- SRAM_DATA_IO  inout  16  bidirectional data bus; driven only during an active read.
- SRAM_ADDRESS_I  input  18  word address from the controller pins.
- SRAM_UB_N_I  input  1  upper byte enable; accepted, not used for masking.
- SRAM_LB_N_I  input  1  lower byte enable; accepted, not used for masking.
- SRAM_WE_N_I  input  1  write enable, active low.
- SRAM_CE_N_I  input  1  chip enable, active low.
- SRAM_OE_N_I  input  1  output enable, active low.
- load_en  input  1  backdoor write strobe.
- load_addr  input  ADDR_BITS  backdoor address.
- load_data  input  16  backdoor data.
- drive_en  output  1  high while the emulator drives SRAM_DATA_IO.
- read_count  output  18  number of active read cycles, wrapping.
- write_count  output  18  number of committed pin writes, wrapping.
- oob_error  output  1  sticky flag: an active access had a nonzero address above ADDR_BITS.

## Operation
- The memory array holds 2^ADDR_BITS × 16 bits. It has no reset; contents persist across Resetn, as on the real chip.
- Effective address is SRAM_ADDRESS_I[ADDR_BITS-1:0]. Higher bits alias, and oob_error flags them.
- Active read: CE_N=0, OE_N=0, WE_N=1.
  - drive_en=1.
  - SRAM_DATA_IO is combinationally driven with mem[eff_addr]. The read is asynchronous, like the chip.
- Otherwise: drive_en=0 and SRAM_DATA_IO is high-Z.
- Active write: CE_N=0 and WE_N=0. OE_N is don't-care; WE has priority.
  - At posedge Clock_50, mem[eff_addr] ← SRAM_DATA_IO, and write_count increments.
  - Both bytes are always written. UB_N/LB_N toggle at 100 MHz and are not sampled.
- Backdoor load: at posedge Clock_50 with load_en=1 and Resetn=1, mem[load_addr] ← load_data.
  - If a pin write targets the same address in the same cycle, the pin write wins.
  - The backdoor does not affect the counters.
- read_count increments at each posedge on which an active read is present.
- oob_error sets at a posedge on which an access is active (read or write) and SRAM_ADDRESS_I[17:ADDR_BITS] != 0. It clears only on reset.
- When ADDR_BITS=18, oob_error is tied 0.
- Reset mid-operation:
  - Counters and the flag clear immediately (asynchronously).
  - Any write on the reset edge is dropped.
  - The combinational read path stays live; the controller holds CE_N/OE_N high in reset, so the bus is high-Z.

## Timing
- Reset values: drive_en=0 (CE_N high in reset), read_count=0, write_count=0, oob_error=0, SRAM_DATA_IO=Z.
- Read latency, end to end:
  - User address at cycle 0 reaches the pins after edge 1.
  - The emulator presents data combinationally during cycle 1.
  - The controller captures it at edge 2, which is the 2-cycle latency.
- Write: the controller's WE_N_O and write buffer are valid together for one cycle. The emulator commits at the closing edge of that cycle.
- Read-after-write, same address, back-to-back cycles: the write commits at the edge ending cycle k, so a read in cycle k+1 returns the new data.
- drive_en and the bus driver switch combinationally with WE_N/OE_N/CE_N. There is no overlap with the controller driving, because the controller drives only when WE_N_O=0.
- Counters are 18-bit and wrap from 2^18-1 to 0.

## Test plan
- Preload: load 0x0000→16'h1234 and 0x0FFF→16'hABCD, then user-read both → SRAM_read_data=16'h1234 and 16'hABCD exactly 2 cycles after each address; read_count=2.
- Pin write then read: write 16'hBEEF to address 5, read address 5 next cycle → 16'hBEEF; write_count=1; drive_en=0 during the write cycle.
- Collision: backdoor 16'h1111 and pin write 16'h2222 to address 7 on the same edge → address 7 reads 16'h2222.
- Aliasing (ADDR_BITS=12): write 16'h5A5A to 18'h01003, then read 18'h00003 → 16'h5A5A; oob_error=1 and stays 1 until Resetn.
- Reset mid-stream: assert Resetn low during a burst of 10 reads → counters=0 and oob_error=0 immediately; bus Z; memory contents unchanged after reset release.
- Wrap: force 2^18 writes → write_count returns to 0.

Source files
------------

// File: rtl/sram_emulator.sv
// Synthesizable stand-in for the external 16-bit asynchronous SRAM on the controller's pin side.
// Asynchronous read, clocked write, backdoor preload port and activity/error counters.
module sram_emulator #(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 Clock_50,
    input  logic                 Resetn,
    inout  wire  [15:0]          SRAM_DATA_IO,
    input  logic [17:0]          SRAM_ADDRESS_I,
    input  logic                 SRAM_UB_N_I,
    input  logic                 SRAM_LB_N_I,
    input  logic                 SRAM_WE_N_I,
    input  logic                 SRAM_CE_N_I,
    input  logic                 SRAM_OE_N_I,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [15:0]          load_data,
    output logic                 drive_en,
    output logic [17:0]          read_count,
    output logic [17:0]          write_count,
    output logic                 oob_error
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [15:0]          r_mem [DEPTH];
    logic [17:0]          r_read_count;
    logic [17:0]          r_write_count;
    logic                 r_oob_error;

    logic [ADDR_BITS-1:0] w_eff_addr;
    logic                 w_rd_active;
    logic                 w_wr_active;
    logic                 w_oob_addr;
    logic                 w_unused_byte_en;

    assign w_eff_addr  = SRAM_ADDRESS_I[ADDR_BITS-1:0];
    assign w_rd_active = !SRAM_CE_N_I && !SRAM_OE_N_I && SRAM_WE_N_I;
    assign w_wr_active = !SRAM_CE_N_I && !SRAM_WE_N_I;

    // Byte enables toggle faster than this clock; both bytes are always written.
    assign w_unused_byte_en = SRAM_UB_N_I ^ SRAM_LB_N_I;

    generate
        if (ADDR_BITS < 18) begin : g_oob
            assign w_oob_addr = |SRAM_ADDRESS_I[17:ADDR_BITS];
        end else begin : g_no_oob
            assign w_oob_addr = 1'b0;
        end
    endgenerate

    assign drive_en     = w_rd_active;
    assign SRAM_DATA_IO = w_rd_active ? r_mem[w_eff_addr] : 16'bz;

    // Array has no reset; writes on a reset edge are dropped. Pin write is
    // assigned last so it wins an address collision with the backdoor.
    always_ff @(posedge Clock_50) begin
        if (Resetn) begin
            if (load_en) begin
                r_mem[load_addr] <= load_data;
            end
            if (w_wr_active) begin
                r_mem[w_eff_addr] <= SRAM_DATA_IO;
            end
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_read_count  <= '0;
            r_write_count <= '0;
            r_oob_error   <= 1'b0;
        end else begin
            if (w_rd_active) begin
                r_read_count <= r_read_count + 18'd1;
            end
            if (w_wr_active) begin
                r_write_count <= r_write_count + 18'd1;
            end
            if ((w_rd_active || w_wr_active) && w_oob_addr) begin
                r_oob_error <= 1'b1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
    assign oob_error   = r_oob_error;

endmodule

// File: tb/tb_sram_emulator.sv
// Bench for sram_emulator: a small pin-registered controller model drives the
// pins; read captures are checked against a scoreboard by a separate monitor.
module tb_sram_emulator;

    localparam int unsigned AB = 12;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    wire  [15:0]    bus;

    logic [17:0]    p_addr;
    logic           p_we_n, p_oe_n, p_ce_n;
    logic [15:0]    p_wbuf;
    logic           load_en;
    logic [AB-1:0]  load_addr;
    logic [15:0]    load_data;
    logic           drive_en;
    logic [17:0]    rc, wc;
    logic           oob;

    logic           u_rd, u_wr;
    logic [17:0]    u_addr;
    logic [15:0]    u_wdata;
    logic           rd_pend, rd_valid;
    logic [15:0]    rd_data;
    int             cyc = 0;
    logic           mute = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    always #10 clk = ~clk;

    sram_emulator #(.ADDR_BITS(AB)) dut (
        .Clock_50      (clk),
        .Resetn        (rstn),
        .SRAM_DATA_IO  (bus),
        .SRAM_ADDRESS_I(p_addr),
        .SRAM_UB_N_I   (1'b0),
        .SRAM_LB_N_I   (1'b0),
        .SRAM_WE_N_I   (p_we_n),
        .SRAM_CE_N_I   (p_ce_n),
        .SRAM_OE_N_I   (p_oe_n),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .drive_en      (drive_en),
        .read_count    (rc),
        .write_count   (wc),
        .oob_error     (oob)
    );

    // Controller drives the bus only while its WE_N output is low.
    assign bus = (!p_we_n && !p_ce_n) ? p_wbuf : 16'bz;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_ce_n   <= 1'b1;
            p_oe_n   <= 1'b1;
            p_we_n   <= 1'b1;
            p_addr   <= '0;
            p_wbuf   <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            p_addr   <= u_addr;
            p_wbuf   <= u_wdata;
            p_we_n   <= !u_wr;
            p_oe_n   <= !u_rd;
            p_ce_n   <= !(u_rd || u_wr);
            rd_pend  <= u_rd;
            rd_valid <= rd_pend;
            rd_data  <= bus;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_valid && !mute) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got %h at cycle %0d, no read outstanding", rd_data, cyc);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || cyc != e.at) begin
                    errors++;
                    $display("FAIL rd_data got %h at cycle %0d, want %h at cycle %0d",
                             rd_data, cyc, e.data, e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc_rd(input logic [17:0] a, input logic [15:0] d);
        exp_t x;
        u_rd = 1'b1; u_wr = 1'b0; u_addr = a;
        x.data = d; x.at = cyc + 2;
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic cyc_wr(input logic [17:0] a, input logic [15:0] d);
        u_rd = 1'b0; u_wr = 1'b1; u_addr = a; u_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        u_rd = 1'b0; u_wr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [AB-1:0] a, input logic [15:0] d);
        u_rd = 1'b0; u_wr = 1'b0;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        u_rd = 1'b0; u_wr = 1'b0; u_addr = '0; u_wdata = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        check("rst_drive_en", {17'd0, drive_en}, 18'd0);
        check("rst_read_count", rc, 18'd0);
        check("rst_write_count", wc, 18'd0);
        check("rst_oob", {17'd0, oob}, 18'd0);
        rstn = 1'b1;
        @(negedge clk);

        load(12'h000, 16'h1234);
        load(12'hFFF, 16'hABCD);
        cyc_rd(18'h00000, 16'h1234);
        cyc_rd(18'h00FFF, 16'hABCD);
        idle(3);
        check("preload_read_count", rc, 18'd2);
        check("preload_write_count", wc, 18'd0);

        cyc_wr(18'd5, 16'hBEEF);
        check("wr_drive_en", {17'd0, drive_en}, 18'd0);
        check("wr_bus", {2'b00, bus}, {2'b00, 16'hBEEF});
        cyc_rd(18'd5, 16'hBEEF);
        idle(3);
        check("wr_write_count", wc, 18'd1);
        check("wr_read_count", rc, 18'd3);

        cyc_wr(18'd7, 16'h2222);
        load(12'd7, 16'h1111);
        cyc_rd(18'd7, 16'h2222);
        idle(3);
        check("coll_write_count", wc, 18'd2);

        check("oob_before", {17'd0, oob}, 18'd0);
        cyc_wr(18'h01003, 16'h5A5A);
        idle(2);
        check("oob_set", {17'd0, oob}, 18'd1);
        cyc_rd(18'h00003, 16'h5A5A);
        idle(3);
        check("oob_sticky", {17'd0, oob}, 18'd1);
        check("alias_write_count", wc, 18'd3);
        check("alias_read_count", rc, 18'd5);

        // Burst of reads interrupted by an asynchronous reset mid-cycle.
        mute = 1'b1;
        u_rd = 1'b1; u_wr = 1'b0; u_addr = '0;
        repeat (4) @(negedge clk);
        check("burst_read_count", rc, 18'd8);
        #2 rstn = 1'b0;
        #1;
        check("midrst_read_count", rc, 18'd0);
        check("midrst_write_count", wc, 18'd0);
        check("midrst_oob", {17'd0, oob}, 18'd0);
        check("midrst_drive_en", {17'd0, drive_en}, 18'd0);
        u_rd = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(1);
        mute = 1'b0;
        cyc_rd(18'h00000, 16'h1234);
        cyc_rd(18'h00FFF, 16'hABCD);
        cyc_rd(18'd5, 16'hBEEF);
        cyc_rd(18'd3, 16'h5A5A);
        cyc_rd(18'd7, 16'h2222);
        idle(3);
        check("post_rst_read_count", rc, 18'd5);
        check("post_rst_write_count", wc, 18'd0);

        force dut.r_write_count = 18'h3FFFE;
        #1;
        release dut.r_write_count;
        cyc_wr(18'd9, 16'h0001);
        cyc_wr(18'd9, 16'h0002);
        check("wrap_last", wc, 18'h3FFFF);
        idle(2);
        check("wrap_zero", wc, 18'd0);
        cyc_rd(18'd9, 16'h0002);
        idle(3);

        check("sb_drained", 18'(sb.size()), 18'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
